// File: rtl/conv1x1_sequencer.sv
// Sequences the 16-lane 1x1 conv datapath: pixel -> output channel -> input group.
// Result written 3 cycles after its last-group read; output writes are never stalled.
module conv1x1_sequencer #(
  parameter int INCH   = 64,
  parameter int INSIZE = 55,
  parameter int OUTCH  = 64,
  parameter int IMG_AW = 16,
  parameter int KER_AW = 12,
  parameter int OUT_AW = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     relu_en,
  output logic                     busy,
  output logic                     done,
  output logic                     img_rd_en,
  output logic [IMG_AW-1:0]        img_addr,
  output logic                     ker_rd_en,
  output logic [KER_AW-1:0]        ker_addr,
  output logic [$clog2(OUTCH)-1:0] bias_addr,
  output logic                     conv_valid,
  output logic                     conv_first,
  input  logic [15:0]              conv_result,
  output logic                     out_wr_en,
  output logic [OUT_AW-1:0]        out_addr,
  output logic [15:0]              out_wr_data
);

  localparam int GROUPS = INCH / 16;
  localparam int NPIX   = INSIZE * INSIZE;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int OW     = $clog2(OUTCH);
  localparam int PW     = (NPIX > 1) ? $clog2(NPIX) : 1;

  localparam logic [GW-1:0]     GRP_LAST = GW'(GROUPS - 1);
  localparam logic [OW-1:0]     OC_LAST  = OW'(OUTCH - 1);
  localparam logic [PW-1:0]     PIX_LAST = PW'(NPIX - 1);
  localparam logic [OUT_AW-1:0] OUT_LAST = OUT_AW'(NPIX * OUTCH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [GW-1:0]     grp;
  logic [OW-1:0]     oc;
  logic [PW-1:0]     pix;
  logic [IMG_AW-1:0] pix_base;
  logic              relu_q;
  logic              vld1, first1, last1, last2;
  logic              accept, issue, grp_wrap, oc_wrap, pix_last;

  assign accept   = (state == S_IDLE) && start;
  assign issue    = (state == S_RUN);
  assign grp_wrap = (grp == GRP_LAST);
  assign oc_wrap  = (oc == OC_LAST);
  assign pix_last = (pix == PIX_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (grp_wrap && oc_wrap && pix_last) state_nxt = S_DRAIN;
      S_DRAIN: if (out_wr_en && out_addr == OUT_LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    img_rd_en = 1'b0;
    ker_rd_en = 1'b0;
    case (state)
      S_RUN: begin
        busy      = 1'b1;
        img_rd_en = 1'b1;
        ker_rd_en = 1'b1;
      end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Incrementing address registers; img_addr rewinds to the pixel base for each new kernel.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      grp      <= '0;
      oc       <= '0;
      pix      <= '0;
      img_addr <= '0;
      pix_base <= '0;
      ker_addr <= '0;
    end else if (issue) begin
      grp <= grp_wrap ? '0 : grp + GW'(1);
      if (grp_wrap) begin
        oc <= oc_wrap ? '0 : oc + OW'(1);
        if (oc_wrap) pix <= pix_last ? '0 : pix + PW'(1);
      end
      if (grp_wrap && !oc_wrap) img_addr <= pix_base;
      else                      img_addr <= img_addr + IMG_AW'(1);
      if (grp_wrap && oc_wrap) begin
        pix_base <= img_addr + IMG_AW'(1);
        ker_addr <= '0;
      end else begin
        ker_addr <= ker_addr + KER_AW'(1);
      end
    end
  end

  assign bias_addr = oc;

  always_ff @(posedge clk) begin
    if (rst)         relu_q <= 1'b0;
    else if (accept) relu_q <= relu_en;
  end

  // Result of a last-group issue at t is complete at t+2 and written at t+3.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld1        <= 1'b0;
      first1      <= 1'b0;
      last1       <= 1'b0;
      last2       <= 1'b0;
      out_wr_en   <= 1'b0;
      out_wr_data <= '0;
      out_addr    <= '0;
    end else begin
      vld1      <= issue;
      first1    <= issue && (grp == '0);
      last1     <= issue && grp_wrap;
      last2     <= last1;
      out_wr_en <= last2;
      if (last2) out_wr_data <= (relu_q && conv_result[15]) ? 16'h0000 : conv_result;
      if (accept)         out_addr <= '0;
      else if (out_wr_en) out_addr <= out_addr + OUT_AW'(1);
    end
  end

  assign conv_valid = vld1;
  assign conv_first = first1;

endmodule
